// File: rtl/fetch_unit_pkg.sv
// Fetch unit shared definitions: reset vector, FSM encoding,
// and the word bundle carried through the skid buffer and IF/ID register.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] LINK_OFS  = 32'd8;

    typedef enum logic {
        ST_ISSUE = 1'b0,
        ST_WAIT  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        adel;
    } fetch_word_t;

    function automatic logic [31:0] pc_add(
        input logic [31:0] pc,
        input logic [31:0] ofs
    );
        return pc + ofs;
    endfunction

endpackage

// File: rtl/fetch_unit_skid.sv
// One-entry skid buffer parking a fetched word while decode is stalled.
// Push has priority; the top never pushes and pops in the same cycle.
module fetch_skid
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic        pop_i,
    input  fetch_word_t data_i,
    output logic        full_o,
    output fetch_word_t data_o
);

    logic        full_q;
    logic        full_d;
    fetch_word_t data_q;
    fetch_word_t data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (push_i) begin
            full_d = 1'b1;
            data_d = data_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, IF/ID register,
// skid buffer for stalls, delayed-branch redirect and misaligned-PC trap.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc8_D,
    output logic        valid_D,
    output logic        adel_D
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  pc_f_q;
    logic [31:0]  pc_f_d;
    logic [31:0]  req_pc_q;
    logic [31:0]  req_pc_d;
    logic         pend_q;
    logic         pend_d;
    logic [31:0]  pend_pc_q;
    logic [31:0]  pend_pc_d;
    logic         err_q;
    logic         err_d;

    fetch_word_t  d_q;
    fetch_word_t  d_d;
    logic         valid_q;
    logic         valid_d;
    logic [31:0]  pc8_q;
    logic [31:0]  pc8_d;

    logic         aligned;
    logic         redir;
    logic         ds_fresh;
    logic         wrong_path;
    logic         can_fetch;
    logic         req;
    logic         inject;
    logic         issue;
    logic         resp_v;
    fetch_word_t  resp;
    logic         skid_full;
    logic         skid_push;
    logic         skid_pop;
    fetch_word_t  skid_data;

    assign aligned  = (pc_f_q[1:0] == 2'b00);
    assign redir    = redirect_i && valid_q && !stall_i;
    assign ds_fresh = (pc_f_q == pc_add(d_q.pc, PC_STEP));

    // Delay slot already out: whatever pc_f points at now is wrong-path.
    assign wrong_path = redir && !ds_fresh;

    assign can_fetch = (state_q == ST_ISSUE) && !skid_full
                    && !wrong_path && !reset;
    assign req       = can_fetch && aligned;
    assign inject    = can_fetch && !aligned && !err_q;
    assign issue     = req && imem_gnt;

    assign resp_v = ((state_q == ST_WAIT) && imem_rvalid) || inject;

    always_comb begin
        resp.instr = imem_rdata;
        resp.pc    = req_pc_q;
        resp.adel  = 1'b0;
        if (inject) begin
            resp.instr = NOP_INSTR;
            resp.pc    = pc_f_q;
            resp.adel  = 1'b1;
        end
    end

    assign skid_push = resp_v && stall_i && valid_q;
    assign skid_pop  = !stall_i && skid_full;

    fetch_skid u_skid (
        .clk    (clk),
        .reset  (reset),
        .push_i (skid_push),
        .pop_i  (skid_pop),
        .data_i (resp),
        .full_o (skid_full),
        .data_o (skid_data)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ISSUE: if (issue) state_d = ST_WAIT;
            ST_WAIT:  if (imem_rvalid) state_d = ST_ISSUE;
        endcase
    end

    always_comb begin
        pc_f_d    = pc_f_q;
        req_pc_d  = req_pc_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        err_d     = err_q;
        if (inject) begin
            err_d = 1'b1;
        end
        if (issue) begin
            req_pc_d = pc_f_q;
            pc_f_d   = pend_q ? pend_pc_q : pc_add(pc_f_q, PC_STEP);
            pend_d   = 1'b0;
        end
        if (redir) begin
            err_d = 1'b0;
            if (!ds_fresh || issue) begin
                pc_f_d = redirect_pc_i;
            end else begin
                pend_d    = 1'b1;
                pend_pc_d = redirect_pc_i;
            end
        end
    end

    always_comb begin
        d_d     = d_q;
        valid_d = valid_q;
        pc8_d   = pc8_q;
        if (!stall_i) begin
            if (skid_full) begin
                d_d     = skid_data;
                valid_d = 1'b1;
                pc8_d   = pc_add(skid_data.pc, LINK_OFS);
            end else if (resp_v) begin
                d_d     = resp;
                valid_d = 1'b1;
                pc8_d   = pc_add(resp.pc, LINK_OFS);
            end else begin
                d_d.instr = NOP_INSTR;
                d_d.adel  = 1'b0;
                valid_d   = 1'b0;
            end
        end else if (!valid_q && resp_v) begin
            d_d     = resp;
            valid_d = 1'b1;
            pc8_d   = pc_add(resp.pc, LINK_OFS);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_ISSUE;
            pc_f_q    <= RESET_PC;
            req_pc_q  <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            err_q     <= 1'b0;
            d_q       <= '0;
            valid_q   <= 1'b0;
            pc8_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_f_q    <= pc_f_d;
            req_pc_q  <= req_pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            err_q     <= err_d;
            d_q       <= d_d;
            valid_q   <= valid_d;
            pc8_q     <= pc8_d;
        end
    end

    assign imem_req  = req;
    assign imem_addr = pc_f_q;
    assign instr_D   = d_q.instr;
    assign pc_D      = d_q.pc;
    assign pc8_D     = pc8_q;
    assign valid_D   = valid_q;
    assign adel_D    = d_q.adel;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed sequences push expected fetch
// addresses and decode words; monitors pop and compare as the DUT produces them.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc8_D;
    logic        valid_D;
    logic        adel_D;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_D       (instr_D),
        .pc_D          (pc_D),
        .pc8_D         (pc8_D),
        .valid_D       (valid_D),
        .adel_D        (adel_D)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc8;
        logic        adel;
    } dexp_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] iss_q[$];
    dexp_t       d_q[$];

    int          lat = 1;
    int          grant_limit = 0;
    int          grants_done = 0;
    logic        m_pend = 1'b0;
    logic [31:0] m_addr = '0;
    int          m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_d(input logic [31:0] pc, input logic [31:0] instr,
                         input logic adel);
        dexp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.pc8   = pc + 32'd8;
        e.adel  = adel;
        d_q.push_back(e);
    endtask

    // Memory: grants up to grant_limit requests, answers after lat cycles.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (m_pend) begin
                m_cnt--;
                if (m_cnt <= 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = m_addr ^ 32'hDEAD_0000;
                    m_pend      = 1'b0;
                end
            end
            imem_gnt = (grants_done < grant_limit);
            #4;
            if (!reset && imem_req && imem_gnt) begin
                m_pend = 1'b1;
                m_addr = imem_addr;
                m_cnt  = lat;
                grants_done++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!reset && imem_req && imem_gnt) begin
                if (iss_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL issue: unexpected fetch %h", imem_addr);
                end else begin
                    check("issue_addr", imem_addr, iss_q.pop_front());
                end
            end
        end
    end

    initial begin
        dexp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!reset && valid_D && !stall_i) begin
                if (d_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL d_word: unexpected pc_D %h", pc_D);
                end else begin
                    e = d_q.pop_front();
                    check("d_pc", pc_D, e.pc);
                    check("d_instr", instr_D, e.instr);
                    check("d_pc8", pc8_D, e.pc8);
                    check("d_adel", {31'b0, adel_D}, {31'b0, e.adel});
                end
            end
        end
    end

    task automatic do_reset(input int n_grant);
        reset      = 1'b1;
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        grant_limit = grants_done + n_grant;
        @(negedge clk);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, valid_D}, 32'd0);
        check("rst_instr", instr_D, 32'h0);
        check("rst_pc", pc_D, 32'h0);
        check("rst_pc8", pc8_D, 32'h0);
        check("rst_adel", {31'b0, adel_D}, 32'd0);
        check("rst_addr", imem_addr, 32'h0000_3000);
        reset = 1'b0;
        #1;
        check("first_req", {31'b0, imem_req}, 32'd1);
    endtask

    task automatic wait_pc(input logic [31:0] pc);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (valid_D && pc_D == pc) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL wait_pc: timeout, pc_D %h required %h", pc_D, pc);
    endtask

    task automatic drain();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (iss_q.size() == 0 && d_q.size() == 0 && !valid_D && !m_pend)
                break;
        end
        repeat (3) @(negedge clk);
        check("drain_iss", iss_q.size(), 0);
        check("drain_d", d_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        @(negedge clk);

        // Straight-line fetch from the reset vector.
        iss_q.push_back(32'h0000_3000);
        iss_q.push_back(32'h0000_3004);
        iss_q.push_back(32'h0000_3008);
        exp_d(32'h0000_3000, 32'hDEAD_3000, 1'b0);
        exp_d(32'h0000_3004, 32'hDEAD_3004, 1'b0);
        exp_d(32'h0000_3008, 32'hDEAD_3008, 1'b0);
        do_reset(3);
        wait_pc(32'h0000_3000);
        check("pc8_first", pc8_D, 32'h0000_3008);
        drain();

        // Stall with a response in flight: it parks in the skid buffer.
        iss_q.push_back(32'h0000_300C);
        iss_q.push_back(32'h0000_3010);
        iss_q.push_back(32'h0000_3014);
        exp_d(32'h0000_300C, 32'hDEAD_300C, 1'b0);
        exp_d(32'h0000_3010, 32'hDEAD_3010, 1'b0);
        exp_d(32'h0000_3014, 32'hDEAD_3014, 1'b0);
        grant_limit = grants_done + 3;
        wait_pc(32'h0000_300C);
        stall_i = 1'b1;
        @(negedge clk);
        check("stall_hold", pc_D, 32'h0000_300C);
        @(negedge clk);
        check("skid_block", {31'b0, imem_req}, 32'd0);
        check("stall_hold2", pc_D, 32'h0000_300C);
        @(negedge clk);
        check("skid_block2", {31'b0, imem_req}, 32'd0);
        stall_i = 1'b0;
        @(negedge clk);
        check("skid_to_d", pc_D, 32'h0000_3010);
        drain();

        // Branch at 3004 whose delay slot is already fetched.
        iss_q.push_back(32'h0000_3000);
        iss_q.push_back(32'h0000_3004);
        iss_q.push_back(32'h0000_3008);
        iss_q.push_back(32'h0000_3100);
        iss_q.push_back(32'h0000_3104);
        exp_d(32'h0000_3000, 32'hDEAD_3000, 1'b0);
        exp_d(32'h0000_3004, 32'hDEAD_3004, 1'b0);
        exp_d(32'h0000_3008, 32'hDEAD_3008, 1'b0);
        exp_d(32'h0000_3100, 32'hDEAD_3100, 1'b0);
        exp_d(32'h0000_3104, 32'hDEAD_3104, 1'b0);
        do_reset(5);
        wait_pc(32'h0000_3004);
        stall_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ds_in_skid", {31'b0, imem_req}, 32'd0);
        stall_i       = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_3100;
        @(negedge clk);
        redirect_i = 1'b0;
        check("ds_enter", pc_D, 32'h0000_3008);
        drain();

        // Same branch, delay slot not yet granted: it goes out first.
        iss_q.push_back(32'h0000_3000);
        iss_q.push_back(32'h0000_3004);
        iss_q.push_back(32'h0000_3008);
        iss_q.push_back(32'h0000_3100);
        iss_q.push_back(32'h0000_3104);
        exp_d(32'h0000_3000, 32'hDEAD_3000, 1'b0);
        exp_d(32'h0000_3004, 32'hDEAD_3004, 1'b0);
        exp_d(32'h0000_3008, 32'hDEAD_3008, 1'b0);
        exp_d(32'h0000_3100, 32'hDEAD_3100, 1'b0);
        exp_d(32'h0000_3104, 32'hDEAD_3104, 1'b0);
        do_reset(2);
        wait_pc(32'h0000_3004);
        check("ds_req_addr", imem_addr, 32'h0000_3008);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_3100;
        @(negedge clk);
        redirect_i = 1'b0;
        check("ds_pending", imem_addr, 32'h0000_3008);
        grant_limit = grants_done + 3;
        drain();

        // jr to a misaligned target, trap held, then redirect to wrap point.
        iss_q.push_back(32'h0000_3000);
        iss_q.push_back(32'h0000_3004);
        iss_q.push_back(32'h0000_3008);
        iss_q.push_back(32'hFFFF_FFFC);
        iss_q.push_back(32'h0000_0000);
        exp_d(32'h0000_3000, 32'hDEAD_3000, 1'b0);
        exp_d(32'h0000_3004, 32'hDEAD_3004, 1'b0);
        exp_d(32'h0000_3008, 32'hDEAD_3008, 1'b0);
        exp_d(32'h0000_3102, 32'h0000_0000, 1'b1);
        exp_d(32'hFFFF_FFFC, 32'h2152_FFFC, 1'b0);
        exp_d(32'h0000_0000, 32'hDEAD_0000, 1'b0);
        do_reset(2);
        wait_pc(32'h0000_3004);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_3102;
        @(negedge clk);
        redirect_i  = 1'b0;
        grant_limit = grants_done + 1;
        wait_pc(32'h0000_3102);
        check("adel_flag", {31'b0, adel_D}, 32'd1);
        check("adel_instr", instr_D, 32'h0);
        stall_i     = 1'b1;
        grant_limit = grants_done + 2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("adel_hold", {31'b0, imem_req}, 32'd0);
        end
        stall_i       = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_i = 1'b0;
        drain();

        // Reset while a request is outstanding; its late response is dropped.
        lat = 2;
        iss_q.push_back(32'h0000_3000);
        do_reset(1);
        for (int i = 0; i < 20; i++) begin
            if (grants_done == grant_limit) break;
            @(negedge clk);
        end
        check("pre_reset_issue", grants_done, grant_limit);
        iss_q.push_back(32'h0000_3000);
        exp_d(32'h0000_3000, 32'hDEAD_3000, 1'b0);
        do_reset(1);
        drain();
        lat = 1;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
